// File: rtl/vg_vmem_responder.sv
// Vector-RAM port arbiter: serves CPU byte accesses and VG 16-bit word fetches over one 8-bit memory.
// Optional macro VMEM_FAIR_ARB_EN adds a starvation counter so the VG eventually beats a busy CPU.
module vg_vmem_responder (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [11:0] fetch_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        vmem_not,
  output logic [15:0] vg_data,
  output logic        vg_valid,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    VG_LO,
    VG_HI,
    VG_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_cpu_go;
  logic        w_vg_go;
  logic        w_vg_pri;

  logic        r_cpu_phase;
  logic        r_cpu_we;
  logic [12:0] r_mem_addr;
  logic        r_mem_we;
  logic [7:0]  r_mem_wdata;
  logic [7:0]  r_lo_byte;
  logic [15:0] r_vg_data;
  logic        r_vg_valid;
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_ack;

`ifdef VMEM_FAIR_ARB_EN
  logic [2:0]  r_starve;

  // Counts arbitration losses of a waiting VG; reaching 4 hands the VG priority once.
  always_ff @(posedge clk_12MHz) begin
    if (reset)
      r_starve <= 3'd0;
    else if (w_vg_go)
      r_starve <= 3'd0;
    else if (w_cpu_go && fetch_req)
      r_starve <= r_starve + 3'd1;
  end

  assign w_vg_pri = (r_starve == 3'd4);
`else
  assign w_vg_pri = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    w_cpu_go = 1'b0;
    w_vg_go  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req && !(fetch_req && w_vg_pri)) begin
          w_next   = CPU_ACC;
          w_cpu_go = 1'b1;
        end else if (fetch_req) begin
          w_next  = VG_LO;
          w_vg_go = 1'b1;
        end
      end
      CPU_ACC: if (r_cpu_phase) w_next = IDLE;
      VG_LO:   w_next = VG_HI;
      VG_HI:   w_next = VG_DONE;
      VG_DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_12MHz) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Memory outputs are loaded on the edge that enters a state, so read data returns one state later.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      r_cpu_phase <= 1'b0;
      r_cpu_we    <= 1'b0;
      r_mem_addr  <= 13'd0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
      r_lo_byte   <= 8'd0;
      r_vg_data   <= 16'd0;
      r_vg_valid  <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_vg_valid  <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_phase <= (r_state == CPU_ACC) && !r_cpu_phase;

      if (w_cpu_go) begin
        r_mem_addr  <= cpu_addr;
        r_mem_we    <= cpu_we;
        r_mem_wdata <= cpu_wdata;
        r_cpu_we    <= cpu_we;
      end

      if (w_vg_go)
        r_mem_addr <= {fetch_addr, 1'b0};

      case (r_state)
        CPU_ACC: begin
          if (r_cpu_phase) begin
            r_cpu_ack <= 1'b1;
            if (!r_cpu_we) r_cpu_rdata <= mem_rdata;
          end
        end
        VG_LO:   r_mem_addr <= {r_mem_addr[12:1], 1'b1};
        VG_HI:   r_lo_byte  <= mem_rdata;
        VG_DONE: begin
          r_vg_data  <= {mem_rdata, r_lo_byte};
          r_vg_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign vg_data   = r_vg_data;
  assign vg_valid  = r_vg_valid;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign vmem_not  = fetch_req && !r_vg_valid;

endmodule
